// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID boundary it feeds.
// The decode stage imports the same IF/ID layout so both sides agree on field widths.
package instruction_fetch_stage_pkg;

  localparam int IF_ID_PC_WIDTH    = 32;
  localparam int IF_ID_INSTR_WIDTH = 32;

  localparam logic [IF_ID_INSTR_WIDTH-1:0] NOP_INSTRUCTION = 32'b0;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [IF_ID_PC_WIDTH-1:0]    pc;
    logic [IF_ID_INSTR_WIDTH-1:0] instruction;
    logic                         valid;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter: word-aligned, wraps within instruction memory; next PC applied on each edge.
// Priority is reset, branch redirect, freeze hold, then sequential step; pc is a plain flop output.
module pc_register
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_BYTES  = 1024,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [DATA_WIDTH-1:0] branch_address,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] pc_seq
);

  // Clearing the low bits aligns branch targets down; the upper mask wraps out-of-range ones.
  localparam logic [DATA_WIDTH-1:0] ADDR_MASK =
    DATA_WIDTH'(MEM_BYTES - 1) & ~DATA_WIDTH'(PC_STEP - 1);

  assign pc_seq = (pc + DATA_WIDTH'(PC_STEP)) & ADDR_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC & ADDR_MASK;
    end else if (branch_taken) begin
      pc <= branch_address & ADDR_MASK;
    end else if (!freeze) begin
      pc <= pc_seq;
    end
  end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Fetch stage: drives the PC to instruction memory and registers {PC+4, instruction, valid} into IF/ID.
// One-cycle fetch latency; freeze holds PC and IF/ID, a branch redirects the PC and flushes IF/ID.
module instruction_fetch_stage
  import instruction_fetch_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_BYTES  = 1024,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_Freeze,
  input  logic                  i_Branch_Taken,
  input  logic [DATA_WIDTH-1:0] i_Branch_Address,
  input  logic [DATA_WIDTH-1:0] i_Instruction,
  output logic [DATA_WIDTH-1:0] o_Mem_Address,
  output logic [DATA_WIDTH-1:0] o_IF_ID_Pc,
  output logic [DATA_WIDTH-1:0] o_IF_ID_Instruction,
  output logic                  o_IF_ID_Valid
);

  logic [DATA_WIDTH-1:0] pc_seq;

  pc_register #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_BYTES (MEM_BYTES),
    .RESET_PC  (RESET_PC)
  ) u_pc_register (
    .clk           (clk),
    .reset         (reset),
    .freeze        (i_Freeze),
    .branch_taken  (i_Branch_Taken),
    .branch_address(i_Branch_Address),
    .pc            (o_Mem_Address),
    .pc_seq        (pc_seq)
  );

  // A taken branch overrides freeze so the wrong-path instruction never survives in IF/ID.
  always_ff @(posedge clk) begin
    if (reset || i_Branch_Taken) begin
      o_IF_ID_Pc          <= '0;
      o_IF_ID_Instruction <= DATA_WIDTH'(NOP_INSTRUCTION);
      o_IF_ID_Valid       <= 1'b0;
    end else if (!i_Freeze) begin
      o_IF_ID_Pc          <= pc_seq;
      o_IF_ID_Instruction <= i_Instruction;
      o_IF_ID_Valid       <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: directed test-plan scenarios plus a random phase.
module tb_instruction_fetch_stage;

  localparam logic [31:0] MASK = 32'h0000_03FC;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_Freeze = 1'b0;
  logic        i_Branch_Taken = 1'b0;
  logic [31:0] i_Branch_Address = '0;
  logic [31:0] i_Instruction;
  logic [31:0] o_Mem_Address;
  logic [31:0] o_IF_ID_Pc;
  logic [31:0] o_IF_ID_Instruction;
  logic        o_IF_ID_Valid;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t model;
  exp_t sb[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'd0) ? 32'hE3A0_0014 : (32'hA500_0000 | a);
  endfunction

  assign i_Instruction = mem_word(o_Mem_Address);

  instruction_fetch_stage dut (
    .clk                (clk),
    .reset              (reset),
    .i_Freeze           (i_Freeze),
    .i_Branch_Taken     (i_Branch_Taken),
    .i_Branch_Address   (i_Branch_Address),
    .i_Instruction      (i_Instruction),
    .o_Mem_Address      (o_Mem_Address),
    .o_IF_ID_Pc         (o_IF_ID_Pc),
    .o_IF_ID_Instruction(o_IF_ID_Instruction),
    .o_IF_ID_Valid      (o_IF_ID_Valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, predict, then compare just after the rising edge.
  task automatic cyc(input logic rst, input logic fr, input logic br, input logic [31:0] ba);
    exp_t e;
    @(negedge clk);
    reset = rst;
    i_Freeze = fr;
    i_Branch_Taken = br;
    i_Branch_Address = ba;
    e = model;
    if (rst) begin
      e = '0;
    end else if (br) begin
      e = '0;
      e.addr = ba & MASK;
    end else if (!fr) begin
      e.addr  = (model.addr + 32'd4) & MASK;
      e.pc    = (model.addr + 32'd4) & MASK;
      e.instr = mem_word(model.addr);
      e.valid = 1'b1;
    end
    model = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_addr", o_Mem_Address, e.addr);
    check("sb_pc", o_IF_ID_Pc, e.pc);
    check("sb_instr", o_IF_ID_Instruction, e.instr);
    check("sb_valid", {31'b0, o_IF_ID_Valid}, {31'b0, e.valid});
  endtask

  initial begin
    model = '0;

    // Reset then free-run
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("reset_addr", o_Mem_Address, 32'd0);
    check("reset_valid", {31'b0, o_IF_ID_Valid}, 32'd0);
    cyc(0, 0, 0, 0);
    check("first_addr", o_Mem_Address, 32'd4);
    check("first_pc", o_IF_ID_Pc, 32'd4);
    check("first_instr", o_IF_ID_Instruction, 32'hE3A0_0014);
    check("first_valid", {31'b0, o_IF_ID_Valid}, 32'd1);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    check("run_addr", o_Mem_Address, 32'd20);

    // Freeze at PC=8 with IF/ID holding {Pc=8}
    cyc(0, 0, 1, 32'd4);
    cyc(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0);
      check("frz_addr", o_Mem_Address, 32'd8);
      check("frz_pc", o_IF_ID_Pc, 32'd8);
      check("frz_valid", {31'b0, o_IF_ID_Valid}, 32'd1);
    end
    cyc(0, 0, 0, 0);
    check("rel_addr0", o_Mem_Address, 32'd12);
    check("rel_instr", o_IF_ID_Instruction, 32'hA500_0008);
    cyc(0, 0, 0, 0);
    check("rel_addr1", o_Mem_Address, 32'd16);

    // Wrap at the top of memory
    cyc(0, 0, 1, 32'd1016);
    check("wrap_a0", o_Mem_Address, 32'd1016);
    cyc(0, 0, 0, 0);
    check("wrap_a1", o_Mem_Address, 32'd1020);
    check("wrap_pc0", o_IF_ID_Pc, 32'd1020);
    cyc(0, 0, 0, 0);
    check("wrap_a2", o_Mem_Address, 32'd0);
    check("wrap_pc1", o_IF_ID_Pc, 32'd0);
    cyc(0, 0, 0, 0);
    check("wrap_a3", o_Mem_Address, 32'd4);

    // Branch and freeze together, misaligned target
    cyc(0, 1, 1, 32'h0000_0102);
    check("bf_addr", o_Mem_Address, 32'h100);
    check("bf_valid", {31'b0, o_IF_ID_Valid}, 32'd0);
    check("bf_instr", o_IF_ID_Instruction, 32'd0);
    cyc(0, 0, 0, 0);
    check("bf_tgt_instr", o_IF_ID_Instruction, 32'hA500_0100);
    check("bf_tgt_pc", o_IF_ID_Pc, 32'h104);

    // Back-to-back branches, then an out-of-range target
    cyc(0, 0, 1, 32'h40);
    check("bb_addr0", o_Mem_Address, 32'h40);
    check("bb_valid0", {31'b0, o_IF_ID_Valid}, 32'd0);
    cyc(0, 0, 1, 32'h80);
    check("bb_addr1", o_Mem_Address, 32'h80);
    check("bb_valid1", {31'b0, o_IF_ID_Valid}, 32'd0);
    cyc(0, 0, 1, 32'hFFFF_F7FF);
    check("oor_addr", o_Mem_Address, 32'h3FC);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Reset during freeze plus branch
    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 32'h200);
    check("rst_mid_addr", o_Mem_Address, 32'd0);
    check("rst_mid_pc", o_IF_ID_Pc, 32'd0);
    check("rst_mid_valid", {31'b0, o_IF_ID_Valid}, 32'd0);
    cyc(0, 0, 0, 0);
    check("rst_mid_resume", o_IF_ID_Instruction, 32'hE3A0_0014);

    // Random mix of freeze, branch and occasional reset
    for (int i = 0; i < 60; i++) begin
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Front end of the five-stage ARM pipeline. Holds the program counter and drives the instruction memory address. Captures the returned instruction together with PC+4 into the IF/ID pipeline register. Handles hazard freeze, and branch redirect/flush from the execute stage.

## Interface
- `DATA_WIDTH`, 32, width of address and instruction paths
- `MEM_BYTES`, 1024, instruction memory size in bytes (power of two); PC wraps modulo this
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `i_Freeze`  in  1  hazard stall; hold PC and IF/ID
- `i_Branch_Taken`  in  1  execute stage redirect; also flushes IF/ID
- `i_Branch_Address`  in  DATA_WIDTH  branch target byte address
- `i_Instruction`  in  DATA_WIDTH  word returned combinationally by instruction memory for `o_Mem_Address`
- `o_Mem_Address`  out  DATA_WIDTH  current PC, to instruction memory
- `o_IF_ID_Pc`  out  DATA_WIDTH  registered PC+4 of the captured instruction
- `o_IF_ID_Instruction`  out  DATA_WIDTH  registered instruction
- `o_IF_ID_Valid`  out  1  registered; 1 = IF/ID holds a real instruction, 0 = bubble

## Operation
- **PC register:** `o_Mem_Address` is the PC flop output directly, with no combinational path from the inputs.
- **Address masking:** all PC values are masked to `MEM_BYTES-1` with bits [1:0] forced to 0.
  - Misaligned branch targets are silently aligned down.
  - Out-of-range targets wrap.
- **Next-PC priority, per rising edge:**
  1. `reset` → `RESET_PC`.
  2. `i_Branch_Taken` → masked `i_Branch_Address`. Branch wins even when `i_Freeze`=1.
  3. `i_Freeze` → hold.
  4. Otherwise → (PC+4) masked. At `MEM_BYTES-4` this wraps to 0.
- **IF/ID register priority, per rising edge:**
  1. `reset` → Pc=0, Instruction=0, Valid=0.
  2. `i_Branch_Taken` → flush: Pc=0, Instruction=0, Valid=0.
  3. `i_Freeze` → hold all three fields.
  4. Otherwise → Pc=masked PC+4, Instruction=`i_Instruction`, Valid=1.
- **Reset is absolute:** reset asserted mid-operation discards all in-flight state on that edge. There is no partial hold.
- **Freeze and branch together:** PC redirects, IF/ID flushes, and the freeze is ignored for that edge.
- **No internal arithmetic state:** PC+4 is computed at DATA_WIDTH and masked. There is no overflow flag.

## Timing
- **Fetch latency:** an address presented in cycle N appears on the IF/ID outputs after the edge ending cycle N, i.e. 1 cycle.
- **Branch penalty:**
  - Branch asserted in cycle N → `o_Mem_Address`=target in N+1.
  - The IF/ID bubble is visible in N+1.
  - The target instruction is on the IF/ID outputs in N+2.
- **Freeze:** every cycle `i_Freeze`=1 (no branch) holds all outputs bit-exact. Release resumes with the held PC, so no instruction is lost or duplicated.
- **Outputs after reset deassert:** `o_Mem_Address`=`RESET_PC`, all IF/ID outputs 0. The first valid IF/ID arrives one edge after `reset` falls.
- **Timing requirement:** `i_Instruction` is sampled only at the clock edge. The instruction memory read path plus setup must fit one cycle.

## Structure
- **Shared pipeline package:**
  - `NOP_INSTRUCTION` (32'b0).
  - `PC_STEP` (4).
  - IF/ID struct/field widths, reused by the decode stage.
- **Sub-module `pc_register`:**
  - Holds the PC flop, masking, and next-PC priority mux.
  - The top level holds the IF/ID register and instantiates `pc_register`.

## Test plan
- **Reset then free-run.** Reset 2 cycles, then run 5 cycles with a memory model returning `0xE3A0_0014` at address 0. Expect `o_Mem_Address` 0,4,8,12,16 and first IF/ID = {Pc=4, Instr=0xE3A00014, Valid=1}.
- **Wrap.** Branch to 1016, then free-run. Expect addresses 1016,1020,0,4 and IF/ID Pc 1020 then 1024-masked=0.
- **Freeze.** Freeze for 3 cycles at PC=8. Expect `o_Mem_Address` held at 8 and IF/ID held at {Pc=8, Valid=1}. After release, addresses continue 12,16.
- **Branch with freeze.** Assert branch to `0x0000_0102` and freeze simultaneously. Expect next `o_Mem_Address`=0x100, IF/ID flushed to 0/0/0, then the target instruction one cycle later.
- **Flush bubble count.** Two back-to-back branches to 0x40 then 0x80. Expect two consecutive Valid=0 cycles, with PC 0x40 then 0x80.
- **Reset mid-freeze and branch.** Assert reset during active freeze plus branch. Expect `o_Mem_Address`=`RESET_PC` and all IF/ID outputs 0 on that edge.
